// File: rtl/alu_input_loader.sv
// Front end for the board ALU: synchronizes and debounces three load buttons and
// steps operand A, operand B and the opcode from one switch bank in A -> B -> OP order.
module alu_input_loader #(
  parameter int NBITS           = 8,
  parameter int COD_OP          = 6,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NBITS-1:0]  i_switches,
  input  logic              i_btn_a,
  input  logic              i_btn_b,
  input  logic              i_btn_op,
  output logic [NBITS-1:0]  operando_A,
  output logic [NBITS-1:0]  operando_B,
  output logic [COD_OP-1:0] cod_operacion,
  output logic              o_valid,
  output logic [1:0]        o_state
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    WAIT_A  = 2'd0,
    WAIT_B  = 2'd1,
    WAIT_OP = 2'd2,
    READY   = 2'd3
  } state_t;

  // Button vectors are indexed {op, b, a}.
  logic [2:0]       btn_raw;
  logic [2:0]       btn_s1_q, btn_s2_q;
  logic [2:0]       lvl_q, lvl_d, lvl_prev_q, ev_q;
  logic [CW-1:0]    cnt_q [3];
  logic [CW-1:0]    cnt_d [3];
  logic [NBITS-1:0] sw_s1_q, sw_s2_q;

  state_t           state_q, state_d;
  logic             ld_a, ld_b, ld_op, valid_d;
  logic [NBITS-1:0] a_q, b_q;
  logic [COD_OP-1:0] op_q;
  logic             valid_q;

  assign btn_raw = {i_btn_op, i_btn_b, i_btn_a};

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = '0;
      lvl_d[i] = lvl_q[i];
      if (btn_s2_q[i] != lvl_q[i]) begin
        if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) lvl_d[i] = ~lvl_q[i];
        else                                     cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // The event is taken from the registered level history, so it lands one
  // cycle after the debounced level rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1_q   <= '0;
      btn_s2_q   <= '0;
      sw_s1_q    <= '0;
      sw_s2_q    <= '0;
      lvl_q      <= '0;
      lvl_prev_q <= '0;
      ev_q       <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      btn_s1_q   <= btn_raw;
      btn_s2_q   <= btn_s1_q;
      sw_s1_q    <= i_switches;
      sw_s2_q    <= sw_s1_q;
      lvl_q      <= lvl_d;
      lvl_prev_q <= lvl_q;
      ev_q       <= lvl_q & ~lvl_prev_q;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= WAIT_A;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_A:  if (ev_q[0]) state_d = WAIT_B;
      WAIT_B:  if (ev_q[1]) state_d = WAIT_OP;
      WAIT_OP: if (ev_q[2]) state_d = READY;
      READY:   state_d = READY;
      default: state_d = WAIT_A;
    endcase
  end

  // o_valid is a bare strobe with no ready: the ALU samples the operand
  // registers in the cycle it is high; there is no back-pressure.
  always_comb begin
    ld_a    = ev_q[0] && (state_q == WAIT_A  || state_q == READY);
    ld_b    = ev_q[1] && (state_q == WAIT_B  || state_q == READY);
    ld_op   = ev_q[2] && (state_q == WAIT_OP || state_q == READY);
    valid_d = (state_q == WAIT_OP && ev_q[2]) || (state_q == READY && (|ev_q));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      if (ld_a)  a_q  <= sw_s2_q;
      if (ld_b)  b_q  <= sw_s2_q;
      if (ld_op) op_q <= sw_s2_q[COD_OP-1:0];
      valid_q <= valid_d;
    end
  end

  assign operando_A    = a_q;
  assign operando_B    = b_q;
  assign cod_operacion = op_q;
  assign o_valid       = valid_q;
  assign o_state       = state_q;

endmodule

// File: tb/tb_alu_input_loader.sv
// Bench for alu_input_loader: directed scenarios plus random button traffic,
// compared every cycle against a window-based reference of the debounce and load rules.
module tb_alu_input_loader;

  localparam int NB = 8;
  localparam int CO = 6;
  localparam int DB = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NB-1:0] sw = '0;
  logic [2:0]    btn = '0;
  logic [NB-1:0] operando_A, operando_B;
  logic [CO-1:0] cod_operacion;
  logic          o_valid;
  logic [1:0]    o_state;

  int checks = 0;
  int errors = 0;
  int vcount = 0;

  alu_input_loader #(.NBITS(NB), .COD_OP(CO), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .rst_n(rst_n), .i_switches(sw),
    .i_btn_a(btn[0]), .i_btn_b(btn[1]), .i_btn_op(btn[2]),
    .operando_A(operando_A), .operando_B(operando_B),
    .cod_operacion(cod_operacion), .o_valid(o_valid), .o_state(o_state)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit            raw_dly [3][$];
  bit            win     [3][$];
  bit            rise_dly[3][$];
  logic [NB-1:0] sw_dly[$];
  bit            mlvl[3];
  int            mstate;
  logic [NB-1:0] ma, mb;
  logic [CO-1:0] mop;
  bit            mvalid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 3; b++) begin
      raw_dly[b].delete(); raw_dly[b].push_back(1'b0); raw_dly[b].push_back(1'b0);
      rise_dly[b].delete(); rise_dly[b].push_back(1'b0); rise_dly[b].push_back(1'b0);
      win[b].delete();
      mlvl[b] = 1'b0;
    end
    sw_dly.delete(); sw_dly.push_back('0); sw_dly.push_back('0);
    mstate = 0; ma = '0; mb = '0; mop = '0; mvalid = 1'b0;
  endtask

  // One rising edge: a level flips once the last DB synchronized samples all
  // disagree with it; a rise loads two edges later using the switches seen then.
  task automatic model_edge(input logic [2:0] b_in, input logic [NB-1:0] sw_in);
    bit ev[3];
    bit seen, all_diff, rise;
    logic [NB-1:0] swl;
    swl = sw_dly.pop_front();
    sw_dly.push_back(sw_in);
    for (int b = 0; b < 3; b++) begin
      ev[b] = rise_dly[b].pop_front();
      seen = raw_dly[b].pop_front();
      raw_dly[b].push_back(b_in[b]);
      win[b].push_back(seen);
      if (win[b].size() > DB) void'(win[b].pop_front());
      rise = 1'b0;
      if (win[b].size() == DB) begin
        all_diff = 1'b1;
        for (int k = 0; k < DB; k++) if (win[b][k] == mlvl[b]) all_diff = 1'b0;
        if (all_diff) begin
          mlvl[b] = !mlvl[b];
          rise = mlvl[b];
        end
      end
      rise_dly[b].push_back(rise);
    end
    mvalid = 1'b0;
    case (mstate)
      0: if (ev[0]) begin ma = swl; mstate = 1; end
      1: if (ev[1]) begin mb = swl; mstate = 2; end
      2: if (ev[2]) begin mop = swl[CO-1:0]; mstate = 3; mvalid = 1'b1; end
      default: begin
        if (ev[0]) ma = swl;
        if (ev[1]) mb = swl;
        if (ev[2]) mop = swl[CO-1:0];
        mvalid = ev[0] | ev[1] | ev[2];
      end
    endcase
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_A"}, operando_A, ma);
    chk({tag, "_B"}, operando_B, mb);
    chk({tag, "_op"}, cod_operacion, mop);
    chk({tag, "_valid"}, o_valid, mvalid);
    chk({tag, "_state"}, o_state, mstate);
  endtask

  // Advance one clock; inputs are changed only at the falling edge.
  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge(btn, sw);
    #1;
    if (o_valid) vcount++;
    check_outputs("cyc");
    @(negedge clk);
  endtask

  task automatic press(input logic [2:0] m, input int hold);
    btn = m;
    repeat (hold) step();
    btn = '0;
    repeat (DB + 6) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("rst");
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  int lat, v0;

  initial begin
    model_reset();
    @(negedge clk);
    // 1: reset with buttons low
    do_reset();
    chk("t1_state", o_state, 0);
    chk("t1_A", operando_A, 0);
    chk("t1_valid", o_valid, 0);

    // 2: full load sequence and o_valid latency
    sw = 8'hF3; press(3'b001, 10);
    sw = 8'h05; press(3'b010, 10);
    sw = 8'h20; btn = 3'b100; lat = -1; v0 = vcount;
    for (int k = 0; k < 14; k++) begin
      step();
      if (o_valid && lat < 0) lat = k;
    end
    btn = '0; repeat (DB + 6) step();
    chk("t2_latency", lat, 2 + DB + 1);
    chk("t2_pulses", vcount - v0, 1);
    chk("t2_A", operando_A, 8'hF3);
    chk("t2_B", operando_B, 8'h05);
    chk("t2_op", cod_operacion, 6'b100000);
    chk("t2_state", o_state, 3);

    // 3: bounce in READY gives one reload; a lone 3-cycle pulse gives none
    sw = 8'h3C; v0 = vcount;
    for (int r = 0; r < 4; r++) begin
      btn = 3'b001; repeat (3) step();
      btn = 3'b000; step();
    end
    press(3'b001, 10);
    chk("t3_pulses", vcount - v0, 1);
    chk("t3_A", operando_A, 8'h3C);
    sw = 8'hAA; v0 = vcount;
    press(3'b001, 3);
    chk("t3_glitch_pulses", vcount - v0, 0);
    chk("t3_glitch_A", operando_A, 8'h3C);

    // 4: order enforcement
    do_reset();
    sw = 8'h99;
    press(3'b010, 8);
    press(3'b100, 8);
    chk("t4_state", o_state, 0);
    chk("t4_B", operando_B, 0);
    chk("t4_op", cod_operacion, 0);
    sw = 8'h11;
    press(3'b001, 8);
    chk("t4_state_a", o_state, 1);
    chk("t4_A", operando_A, 8'h11);

    // 5: simultaneous A and B in READY
    sw = 8'h22; press(3'b010, 8);
    sw = 8'h0B; press(3'b100, 8);
    sw = 8'h7F; v0 = vcount;
    press(3'b011, 8);
    chk("t5_A", operando_A, 8'h7F);
    chk("t5_B", operando_B, 8'h7F);
    chk("t5_op", cod_operacion, 6'h0B);
    chk("t5_pulses", vcount - v0, 1);
    chk("t5_state", o_state, 3);

    // 6: reset mid-debounce in WAIT_OP
    do_reset();
    sw = 8'h44; press(3'b001, 8);
    sw = 8'h55; press(3'b010, 8);
    sw = 8'h3F; btn = 3'b100;
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    chk("t6_A", operando_A, 0);
    chk("t6_B", operando_B, 0);
    chk("t6_state", o_state, 0);
    model_reset();
    btn = '0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (16) step();
    chk("t6_after_state", o_state, 0);
    chk("t6_after_op", cod_operacion, 0);

    // Random traffic, including glitches, overlaps and occasional resets
    for (int s = 0; s < 80; s++) begin
      sw = NB'($urandom);
      btn = 3'($urandom_range(0, 7));
      repeat ($urandom_range(1, 9)) step();
      btn = 3'($urandom_range(0, 7)) & btn;
      repeat ($urandom_range(0, 4)) step();
      btn = '0;
      repeat ($urandom_range(1, 8)) step();
      if ($urandom_range(0, 24) == 0) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout at %0t: got 0 expected 1", $time);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
